lifi_hadamard_pam_receiver: RTL and testbench

- Parallel-in wrapper around a serial LiFi PHY receiver that decodes one unipolar Hadamard-spread PAM frame into data bits.
- Accepts one frame on input_data: a 4-bit header followed by HADAMARD chip samples.
- Serialises the frame internally (MSB first), de-spreads it by Hadamard correlation and slices each PAM symbol.
- Presents HADAMARD-1 decoded symbols in parallel with a ready flag. Sits between the optical front-end sampler and the MAC.

---
 rtl/lifi_hadamard_pam_receiver_if.sv | 15 +
 rtl/lifi_hadamard_pam_receiver.sv | 163 ++++++++++++++++
 tb/tb_lifi_hadamard_pam_receiver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lifi_hadamard_pam_receiver_if.sv
// Frame-in / symbols-out bundle for the LiFi Hadamard PAM receiver.
// The master drives the frame, and the slave returns the decoded symbols, the ready flag and the FSM state.
interface lifi_hadamard_pam_receiver_if #(
    parameter int N = 100,
    parameter int M = 30
);
    logic [N-1:0] input_data;
    logic [M-1:0] output_data;
    logic         ready;
    logic [1:0]   dbg_state;

    // ready is a level flag: once high it marks output_data as a complete, stable frame until reset.
    modport master (output input_data, input output_data, ready, dbg_state);
    modport slave  (input input_data, output output_data, ready, dbg_state);
endinterface

// File: rtl/lifi_hadamard_pam_receiver.sv
// Serialises one Hadamard-spread PAM frame, de-spreads rows 1..H-1 and slices each symbol.
// Optional macro HEADER_CHECK_EN: a frame whose header is not 4'b1010 is dropped and ready stays low.
module lifi_hadamard_pam_receiver #(
    parameter int HADAMARD      = 16,
    parameter int PAM_LEVEL_LOG = 2,
    parameter int BIT_NUM       = 6,
    parameter int MIDLE_BITS    = 10
) (
    input  logic                          clk,
    input  logic                          resetn,
    lifi_hadamard_pam_receiver_if.slave   bus
);
    localparam int N     = BIT_NUM * HADAMARD + 4;
    localparam int M     = (HADAMARD - 1) * PAM_LEVEL_LOG;
    localparam int LOG_H = $clog2(HADAMARD);
    localparam int CNT_W = $clog2(N + 1);
    localparam int CB_W  = $clog2(BIT_NUM);
    localparam int ACC_W = MIDLE_BITS + 1;
    localparam int RND_W = ACC_W + 1;
    localparam int SMAX  = 2 ** PAM_LEVEL_LOG - 1;

    typedef enum logic [1:0] {LOAD, SHIFT, DECIDE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             sr_q, sr_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CB_W-1:0]          cbit_q, cbit_d;
    logic [LOG_H-1:0]         chip_idx_q, chip_idx_d;
    logic [BIT_NUM-2:0]       chip_q, chip_d;
    logic signed [ACC_W-1:0]  acc_q [1:HADAMARD-1];
    logic signed [ACC_W-1:0]  acc_d [1:HADAMARD-1];
    logic [M-1:0]             out_q, out_d;
    logic                     ready_q, ready_d;
`ifdef HEADER_CHECK_EN
    logic [3:0]               header_q, header_d;
`endif

    logic                     bit_in;
    logic [BIT_NUM-1:0]       chip_full;
    logic signed [ACC_W-1:0]  chip_ext;
    logic [M-1:0]             dec_v;
    logic signed [RND_W-1:0]  rnd_v, sym_v;

    assign bit_in          = sr_q[N-1];
    assign chip_full       = {chip_q, bit_in};
    assign chip_ext        = $signed({{(ACC_W - BIT_NUM){1'b0}}, chip_full});
    assign bus.output_data = out_q;
    assign bus.ready       = ready_q;
    assign bus.dbg_state   = state_q;

    // Slicer: round(acc/(H/2)) half up is (acc + H/4) >>> (log2(H)-1), then clamp to the PAM range.
    always_comb begin
        dec_v = '0;
        rnd_v = '0;
        sym_v = '0;
        for (int k = 1; k < HADAMARD; k++) begin
            rnd_v = $signed({acc_q[k][ACC_W-1], acc_q[k]}) + $signed(RND_W'(HADAMARD / 4));
            sym_v = rnd_v >>> (LOG_H - 1);
            if (sym_v[RND_W-1])
                dec_v[(HADAMARD-1-k)*PAM_LEVEL_LOG +: PAM_LEVEL_LOG] = '0;
            else if (sym_v > $signed(RND_W'(SMAX)))
                dec_v[(HADAMARD-1-k)*PAM_LEVEL_LOG +: PAM_LEVEL_LOG] = PAM_LEVEL_LOG'(SMAX);
            else
                dec_v[(HADAMARD-1-k)*PAM_LEVEL_LOG +: PAM_LEVEL_LOG] = sym_v[PAM_LEVEL_LOG-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        cbit_d     = cbit_q;
        chip_idx_d = chip_idx_q;
        chip_d     = chip_q;
        acc_d      = acc_q;
        out_d      = out_q;
        ready_d    = ready_q;
`ifdef HEADER_CHECK_EN
        header_d   = header_q;
`endif
        case (state_q)
            LOAD: begin
                sr_d    = bus.input_data;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d      = {sr_q[N-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q < CNT_W'(4)) begin
`ifdef HEADER_CHECK_EN
                    header_d = {header_q[2:0], bit_in};
`endif
                end else begin
                    chip_d = chip_full[BIT_NUM-2:0];
                    if (cbit_q == CB_W'(BIT_NUM - 1)) begin
                        cbit_d     = '0;
                        chip_idx_d = chip_idx_q + LOG_H'(1);
                        // Sylvester row k has -1 at column i when popcount(i & k) is odd.
                        for (int k = 1; k < HADAMARD; k++) begin
                            if (^(chip_idx_q & LOG_H'(k)))
                                acc_d[k] = acc_q[k] - chip_ext;
                            else
                                acc_d[k] = acc_q[k] + chip_ext;
                        end
                    end else begin
                        cbit_d = cbit_q + CB_W'(1);
                    end
                end
                if (bit_cnt_q == CNT_W'(N - 1))
                    state_d = DECIDE;
            end
            DECIDE: begin
                state_d = DONE;
`ifdef HEADER_CHECK_EN
                if (header_q == 4'b1010) begin
                    out_d   = dec_v;
                    ready_d = 1'b1;
                end else begin
                    out_d   = '0;
                    ready_d = 1'b0;
                end
`else
                out_d   = dec_v;
                ready_d = 1'b1;
`endif
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= LOAD;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            cbit_q     <= '0;
            chip_idx_q <= '0;
            chip_q     <= '0;
            for (int k = 1; k < HADAMARD; k++) acc_q[k] <= '0;
            out_q      <= '0;
            ready_q    <= 1'b0;
`ifdef HEADER_CHECK_EN
            header_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            cbit_q     <= cbit_d;
            chip_idx_q <= chip_idx_d;
            chip_q     <= chip_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
`ifdef HEADER_CHECK_EN
            header_q   <= header_d;
`endif
        end
    end
endmodule

// File: tb/tb_lifi_hadamard_pam_receiver.sv
// Scoreboard bench for lifi_hadamard_pam_receiver: frames are pushed with their model result,
// and a negedge monitor pops and compares whenever ready rises.
module tb_lifi_hadamard_pam_receiver;
    localparam int H   = 16;
    localparam int P   = 2;
    localparam int BN  = 6;
    localparam int N   = BN * H + 4;
    localparam int M   = (H - 1) * P;

    logic clk;
    logic resetn;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    bit   seen     = 0;
    logic [M-1:0] exp_q[$];

    lifi_hadamard_pam_receiver_if #(.N(N), .M(M)) bus ();

    lifi_hadamard_pam_receiver #(
        .HADAMARD(H), .PAM_LEVEL_LOG(P), .BIT_NUM(BN), .MIDLE_BITS(10)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] make_frame(input logic [3:0] hdr, input int chips [H]);
        logic [N-1:0] f;
        f = '0;
        f[N-1 -: 4] = hdr;
        for (int i = 0; i < H; i++) f[N-5-i*BN -: BN] = BN'(chips[i]);
        return f;
    endfunction

    // Decodes with the matrix definition directly: acc_k = sum_i x_i * H[k][i].
    function automatic logic [M-1:0] model(input logic [N-1:0] f);
        logic [M-1:0] r;
        int x [H];
        int acc, s;
        r = '0;
        for (int i = 0; i < H; i++) x[i] = int'(f[N-5-i*BN -: BN]);
        for (int k = 1; k < H; k++) begin
            acc = 0;
            for (int i = 0; i < H; i++)
                acc += ($countones(i & k) % 2 == 0) ? x[i] : -x[i];
            if (acc < 0) s = 0;
            else s = (2 * acc + H / 2) / H;
            if (s > 2 ** P - 1) s = 2 ** P - 1;
            r[(H-1-k)*P +: P] = P'(s);
        end
        return r;
    endfunction

    // Chips whose correlation on row k is (H/2)*s_k exactly.
    task automatic chips_from_symbols(input int s [H], output int chips [H]);
        for (int i = 0; i < H; i++) begin
            chips[i] = 0;
            for (int k = 1; k < H; k++)
                if ($countones(i & k) % 2 == 0) chips[i] += s[k];
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [M-1:0] e;
        if (resetn) begin
            seen = 0;
        end else if (bus.ready && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(bus.ready), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("output_data", 64'(bus.output_data), 64'(e));
                check("ready_latency", 64'(cyc), 64'(N + 2));
            end
            done_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(bus.ready), 64'd0);
        check("reset_output", 64'(bus.output_data), 64'd0);
    endtask

    task automatic scramble_input();
        logic [127:0] junk;
        junk = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.input_data = junk[N-1:0];
    endtask

    task automatic run_frame(input logic [N-1:0] f, input bit expect_ready, input logic [M-1:0] e);
        int start, waited;
        apply_reset();
        bus.input_data = f;
        if (expect_ready) exp_q.push_back(e);
        start = done_cnt;
        resetn = 1'b0;
        @(posedge clk);
        #1 scramble_input();
        if (expect_ready) begin
            waited = 0;
            while (done_cnt == start && waited < 2 * N) begin
                @(negedge clk);
                waited++;
            end
            if (done_cnt == start) begin
                check("ready_timeout", 64'd0, 64'd1);
                exp_q.delete();
            end else begin
                repeat (5) @(negedge clk);
                check("hold_ready", 64'(bus.ready), 64'd1);
                check("hold_output", 64'(bus.output_data), 64'(e));
            end
        end else begin
            repeat (N + 10) @(negedge clk);
            check("dropped_ready", 64'(bus.ready), 64'd0);
            check("dropped_output", 64'(bus.output_data), 64'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int chips [H];
        int syms [H];
        logic [N-1:0] f;
        resetn = 1'b1;
        bus.input_data = '0;
        @(negedge clk);

        for (int i = 0; i < H; i++) chips[i] = 0;
        run_frame(make_frame(4'b1010, chips), 1, 30'h0);

        for (int i = 0; i < H; i++) chips[i] = (i == 0) ? 45 : 24;
        run_frame(make_frame(4'b1010, chips), 1, 30'h3FFF_FFFF);

        for (int i = 0; i < H; i++) chips[i] = (i % 2 == 0) ? 1 : 0;
        run_frame(make_frame(4'b1010, chips), 1, 30'h1000_0000);

        for (int i = 0; i < H; i++) chips[i] = (i == 0) ? 45 : 24;
        chips[5] = 25;
        run_frame(make_frame(4'b1010, chips), 1, 30'h3FFF_FFFF);

        // Reset in the middle of SHIFT: clear immediately, then decode a fresh frame.
        apply_reset();
        bus.input_data = make_frame(4'b1010, chips);
        resetn = 1'b0;
        repeat (50) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midreset_ready", 64'(bus.ready), 64'd0);
        check("midreset_output", 64'(bus.output_data), 64'd0);
        for (int k = 0; k < H; k++) syms[k] = (k == 0) ? 0 : int'($urandom_range(0, 3));
        chips_from_symbols(syms, chips);
        f = make_frame(4'b1010, chips);
        run_frame(f, 1, model(f));

        // Wrong header on an otherwise valid all-3 frame.
        for (int i = 0; i < H; i++) chips[i] = (i == 0) ? 45 : 24;
        f = make_frame(4'b0000, chips);
`ifdef HEADER_CHECK_EN
        run_frame(f, 0, '0);
`else
        run_frame(f, 1, model(f));
`endif

        // Random frames: clean symbols, symbols with chip noise, raw random chips.
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < H; k++) syms[k] = (k == 0) ? 0 : int'($urandom_range(0, 3));
            chips_from_symbols(syms, chips);
            for (int i = 0; i < H; i++) begin
                if (t % 3 == 1 && chips[i] < 63) chips[i] += int'($urandom_range(0, 1));
                if (t % 3 == 2) chips[i] = int'($urandom_range(0, 63));
            end
            f = make_frame(4'b1010, chips);
            run_frame(f, 1, model(f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
